// File: rtl/tapa_global_fsm_pkg.sv
// Shared types and defaults for the TAPA kernel's top-level control FSM.
// The state encoding is fixed so it stays consistent with debug probes and waveforms.
package tapa_global_fsm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_LAUNCH = 2'b01,
        ST_WAIT   = 2'b11,
        ST_FINISH = 2'b10
    } state_t;

    localparam int DEFAULT_NUM_TASKS = 8;
    localparam int DEFAULT_CNT_W     = 48;

endpackage

// File: rtl/tapa_global_fsm.sv
// Global control FSM: bridges the host ap_ctrl_hs handshake to the per-task FSMs,
// latches the kernel scalars for a run and measures the run length in cycles.
module tapa_global_fsm
    import tapa_global_fsm_pkg::*;
#(
    parameter int NUM_TASKS = DEFAULT_NUM_TASKS,
    parameter int CNT_W     = DEFAULT_CNT_W
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 ap_start,
    output logic                 ap_ready,
    output logic                 ap_done,
    output logic                 ap_idle,
    input  logic [63:0]          s_output_mmap_offset,
    input  logic [31:0]          s_seq_len,
    output logic [63:0]          global_fsm_s_output_mmap_offset,
    output logic [31:0]          global_fsm_s_seq_len,
    output logic                 global_fsm_ap_start,
    output logic                 global_fsm_ap_done,
    input  logic [NUM_TASKS-1:0] task_is_done,
    output logic [CNT_W-1:0]     run_cycles,
    output logic [NUM_TASKS-1:0] pending_mask
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t                 state_reg;
    state_t                 state_next;
    logic [63:0]            offset_reg;
    logic [31:0]            seq_len_reg;
    logic [CNT_W-1:0]       cnt_reg;
    logic [CNT_W-1:0]       run_cycles_reg;
    logic [NUM_TASKS-1:0]   pending_reg;
    logic                   all_done;

    assign all_done = &task_is_done;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (ap_start) state_next = ST_LAUNCH;
            ST_LAUNCH: state_next = ST_WAIT;
            ST_WAIT:   if (all_done) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_reg      <= ST_IDLE;
            offset_reg     <= '0;
            seq_len_reg    <= '0;
            cnt_reg        <= '0;
            run_cycles_reg <= '0;
            pending_reg    <= '0;
        end else begin
            state_reg <= state_next;

            // Scalars are captured only on the launch transition and held for the run.
            if (state_reg == ST_IDLE && ap_start) begin
                offset_reg  <= s_output_mmap_offset;
                seq_len_reg <= s_seq_len;
            end

            case (state_reg)
                ST_LAUNCH: cnt_reg <= '0;
                ST_WAIT:   if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + CNT_ONE;
                ST_FINISH: run_cycles_reg <= cnt_reg;
                default:   ;
            endcase

            // Registered snapshot of outstanding tasks; forced to zero outside WAIT.
            pending_reg <= (state_next == ST_WAIT) ? ~task_is_done : '0;
        end
    end

    assign ap_idle             = (state_reg == ST_IDLE);
    assign global_fsm_ap_start = (state_reg == ST_LAUNCH);
    assign global_fsm_ap_done  = (state_reg == ST_FINISH);
    assign ap_done             = (state_reg == ST_FINISH);
    assign ap_ready            = (state_reg == ST_FINISH);

    assign global_fsm_s_output_mmap_offset = offset_reg;
    assign global_fsm_s_seq_len            = seq_len_reg;
    assign run_cycles                      = run_cycles_reg;
    assign pending_mask                    = pending_reg;

endmodule

// File: tb/tb_tapa_global_fsm.sv
// Self-checking bench for tapa_global_fsm: directed scenarios plus randomized runs,
// with expectations derived from per-task done delays.
module tb_tapa_global_fsm;

    localparam int NT    = 3;
    localparam int SAT_W = 4;
    localparam int SAT_MAX = (1 << SAT_W) - 1;

    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        ap_start;
    logic [63:0] s_off;
    logic [31:0] s_len;
    logic [NT-1:0] task_is_done;

    logic        ap_ready, ap_done, ap_idle, g_start, g_done;
    logic [63:0] g_off;
    logic [31:0] g_len;
    logic [47:0] run_cycles;
    logic [NT-1:0] pending;

    logic        sat_ready, sat_done, sat_idle, sat_gstart, sat_gdone;
    logic [63:0] sat_off;
    logic [31:0] sat_len;
    logic [SAT_W-1:0] sat_run;
    logic [NT-1:0] sat_pending;

    int checks   = 0;
    int failures = 0;

    always #5 ap_clk = ~ap_clk;

    tapa_global_fsm #(.NUM_TASKS(NT), .CNT_W(48)) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_ready(ap_ready), .ap_done(ap_done), .ap_idle(ap_idle),
        .s_output_mmap_offset(s_off), .s_seq_len(s_len),
        .global_fsm_s_output_mmap_offset(g_off), .global_fsm_s_seq_len(g_len),
        .global_fsm_ap_start(g_start), .global_fsm_ap_done(g_done),
        .task_is_done(task_is_done), .run_cycles(run_cycles), .pending_mask(pending)
    );

    tapa_global_fsm #(.NUM_TASKS(NT), .CNT_W(SAT_W)) dut_sat (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .ap_start(ap_start),
        .ap_ready(sat_ready), .ap_done(sat_done), .ap_idle(sat_idle),
        .s_output_mmap_offset(s_off), .s_seq_len(s_len),
        .global_fsm_s_output_mmap_offset(sat_off), .global_fsm_s_seq_len(sat_len),
        .global_fsm_ap_start(sat_gstart), .global_fsm_ap_done(sat_gdone),
        .task_is_done(task_is_done), .run_cycles(sat_run), .pending_mask(sat_pending)
    );

    task automatic tick;
        @(posedge ap_clk);
        @(negedge ap_clk);
    endtask

    // Task i reports done from cycle d_i (counted from the start pulse) onwards.
    function automatic logic [NT-1:0] done_at(input int k, input int d0, input int d1, input int d2);
        done_at = {(k >= d2), (k >= d1), (k >= d0)};
    endfunction

    // One complete run, entered at a negedge while the DUT is idle and left at the
    // negedge of the IDLE cycle that follows FINISH.
    task automatic run_task(input string name, input logic [63:0] off, input logic [31:0] len,
                            input int d0, input int d1, input int d2,
                            input bit hold, input bit change_len);
        int k;
        int exp_n;
        int exp_sat;
        bit finished;
        logic [NT-1:0] cur;
        logic [NT-1:0] exp_pend;

        exp_n   = (d0 > d1) ? d0 : d1;
        exp_n   = (exp_n > d2) ? exp_n : d2;
        exp_sat = (exp_n > SAT_MAX) ? SAT_MAX : exp_n;

        checks++;
        if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL %s idle_entry ctrl got=%b exp=10000", name,
                     {ap_idle, g_start, g_done, ap_done, ap_ready});
        end

        ap_start     = 1'b1;
        s_off        = off;
        s_len        = len;
        task_is_done = '0;
        tick();

        checks++;
        if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b01000) begin
            failures++;
            $display("FAIL %s launch ctrl got=%b exp=01000", name,
                     {ap_idle, g_start, g_done, ap_done, ap_ready});
        end
        checks++;
        if (g_off !== off || g_len !== len) begin
            failures++;
            $display("FAIL %s launch scalars got=%h/%0d exp=%h/%0d", name, g_off, g_len, off, len);
        end

        if (!hold) ap_start = 1'b0;
        tick();

        k = 1;
        finished = 1'b0;
        while (!finished && k <= 200) begin
            exp_pend = ~done_at(k - 1, d0, d1, d2);
            checks++;
            if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b00000) begin
                failures++;
                $display("FAIL %s wait%0d ctrl got=%b exp=00000", name, k,
                         {ap_idle, g_start, g_done, ap_done, ap_ready});
            end
            checks++;
            if (pending !== exp_pend) begin
                failures++;
                $display("FAIL %s wait%0d pending_mask got=%b exp=%b", name, k, pending, exp_pend);
            end
            checks++;
            if (g_off !== off || g_len !== len) begin
                failures++;
                $display("FAIL %s wait%0d scalars got=%h/%0d exp=%h/%0d", name, k, g_off, g_len, off, len);
            end
            if (change_len && k == 2) s_len = 32'd7;
            cur = done_at(k, d0, d1, d2);
            task_is_done = cur;
            tick();
            if (&cur) finished = 1'b1;
            else k++;
        end

        if (!finished) begin
            checks++;
            failures++;
            $display("FAIL %s timeout waiting for all tasks done", name);
            return;
        end

        checks++;
        if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b00111 || pending !== '0) begin
            failures++;
            $display("FAIL %s finish ctrl got=%b pend=%b exp=00111 pend=000", name,
                     {ap_idle, g_start, g_done, ap_done, ap_ready}, pending);
        end
        task_is_done = '0;
        tick();

        checks++;
        if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b10000) begin
            failures++;
            $display("FAIL %s post_idle ctrl got=%b exp=10000", name,
                     {ap_idle, g_start, g_done, ap_done, ap_ready});
        end
        checks++;
        if (run_cycles !== 48'(exp_n)) begin
            failures++;
            $display("FAIL %s run_cycles got=%0d exp=%0d", name, run_cycles, exp_n);
        end
        checks++;
        if (sat_run !== SAT_W'(exp_sat)) begin
            failures++;
            $display("FAIL %s sat_run_cycles got=%0d exp=%0d", name, sat_run, exp_sat);
        end
        checks++;
        if (g_len !== len) begin
            failures++;
            $display("FAIL %s idle seq_len got=%0d exp=%0d", name, g_len, len);
        end
        $display("run %s: off=%h len=%0d delays=%0d/%0d/%0d run_cycles=%0d sat=%0d",
                 name, off, len, d0, d1, d2, run_cycles, sat_run);
    endtask

    task automatic test_reset;
        ap_rst = 1'b1;
        ap_start = 1'b0;
        s_off = 64'h0;
        s_len = 32'h0;
        task_is_done = '0;
        repeat (3) tick();
        checks++;
        if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b10000 || pending !== '0 ||
            g_off !== 64'h0 || g_len !== 32'h0 || run_cycles !== 48'h0 || sat_run !== '0) begin
            failures++;
            $display("FAIL reset_values ctrl=%b pend=%b off=%h len=%0d run=%0d exp ctrl=10000 rest=0",
                     {ap_idle, g_start, g_done, ap_done, ap_ready}, pending, g_off, g_len, run_cycles);
        end
        ap_rst = 1'b0;
        tick();
        $display("reset: ctrl=%b", {ap_idle, g_start, g_done, ap_done, ap_ready});
    endtask

    task automatic test_basic;
        run_task("basic", 64'h1000, 32'd128, 5, 9, 12, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        run_task("b2b_0", 64'h2000, 32'd16, 3, 1, 2, 1'b1, 1'b0);
        run_task("b2b_1", 64'h3000, 32'd17, 4, 6, 2, 1'b1, 1'b0);
        run_task("b2b_2", 64'h4000, 32'd18, 2, 2, 7, 1'b0, 1'b0);
    endtask

    task automatic test_scalar_isolation;
        run_task("scalar_iso", 64'h5000, 32'd128, 4, 5, 6, 1'b0, 1'b1);
        run_task("scalar_next", 64'h5000, 32'd7, 2, 3, 1, 1'b0, 1'b0);
    endtask

    task automatic test_immediate_done;
        run_task("immediate", 64'h6000, 32'd1, 1, 1, 1, 1'b0, 1'b0);
    endtask

    task automatic test_saturation;
        run_task("saturation", 64'h7000, 32'd99, 20, 20, 20, 1'b0, 1'b0);
    endtask

    task automatic test_random;
        logic [63:0] off;
        for (int i = 0; i < 8; i++) begin
            off = {$urandom, $urandom};
            run_task($sformatf("rand%0d", i), off, $urandom,
                     $urandom_range(1, 25), $urandom_range(1, 25), $urandom_range(1, 25),
                     (i < 7) ? 1'($urandom_range(0, 1)) : 1'b0, 1'b0);
        end
    endtask

    task automatic test_reset_mid_run;
        ap_start = 1'b1;
        s_off = 64'hdead_beef_0000_1111;
        s_len = 32'd55;
        task_is_done = '0;
        tick();
        ap_start = 1'b0;
        task_is_done = 3'b101;
        tick();
        tick();
        checks++;
        if (pending !== 3'b010) begin
            failures++;
            $display("FAIL reset_mid pre_pending got=%b exp=010", pending);
        end
        ap_rst = 1'b1;
        tick();
        checks++;
        if ({ap_idle, g_start, g_done, ap_done, ap_ready} !== 5'b10000 || pending !== '0 ||
            g_off !== 64'h0 || g_len !== 32'h0 || run_cycles !== 48'h0) begin
            failures++;
            $display("FAIL reset_mid after_reset ctrl=%b pend=%b off=%h len=%0d run=%0d exp ctrl=10000 rest=0",
                     {ap_idle, g_start, g_done, ap_done, ap_ready}, pending, g_off, g_len, run_cycles);
        end
        ap_rst = 1'b0;
        task_is_done = '0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (ap_done !== 1'b0 || ap_idle !== 1'b1) begin
                failures++;
                $display("FAIL reset_mid quiet%0d ap_done=%b ap_idle=%b exp 0/1", i, ap_done, ap_idle);
            end
        end
        $display("reset_mid: ctrl=%b pend=%b", {ap_idle, g_start, g_done, ap_done, ap_ready}, pending);
    endtask

    initial begin
        @(negedge ap_clk);
        test_reset();
        test_basic();
        test_back_to_back();
        test_scalar_isolation();
        test_immediate_done();
        test_saturation();
        test_random();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
